// File: rtl/ptr_ring_router_v2.sv
// Generic synchronous FIFO with show-ahead read data.
// Latency: a push is visible on pop_dat/empty one cycle after the write edge.
// Backpressure: push ignored while full, pop ignored while empty; full/empty come only from registered pointers.
module ptr_ring_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Extra wrap bit separates full (same slot, different lap) from empty (same slot, same lap).
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign pop_dat = mem[rptr[AW-1:0]];

    // Pointer update; guards make push-on-full and pop-on-empty no-ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because empty masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

// PtRing node router: forwards ring flits with hop/express arithmetic, ejects dest==0 flits, injects local flits.
// Latency: ring_in or injection head to ring_out is one cycle; ring_in to loc_rd_dat is one cycle.
// Backpressure: forward flits stall while the output stage is blocked or a starved injection is forced; eject flits stall on a full ejection FIFO.
module ptr_ring_router_v2 #(
    parameter int DATA_WIDTH = 128,
    parameter int NODE_NUM   = 128,
    parameter int JUMP_STEP  = 4,
    parameter int JUMP_EN    = 1,
    parameter int INJ_DEPTH  = 4,
    parameter int EJ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ring_in_vld,
    output logic                              ring_in_rdy,
    input  logic [DATA_WIDTH-1:0]             ring_in_dat,
    input  logic [$clog2(NODE_NUM)-1:0]       ring_in_dest,
    input  logic                              ring_in_jump,
    output logic                              ring_out_vld,
    input  logic                              ring_out_rdy,
    output logic [DATA_WIDTH-1:0]             ring_out_dat,
    output logic [$clog2(NODE_NUM)-1:0]       ring_out_dest,
    output logic                              ring_out_jump,
    input  logic                              loc_wr,
    input  logic [DATA_WIDTH-1:0]             loc_wr_dat,
    input  logic [$clog2(NODE_NUM)-1:0]       loc_wr_dest,
    output logic                              loc_full,
    input  logic                              loc_rd,
    output logic [DATA_WIDTH-1:0]             loc_rd_dat,
    output logic                              loc_empty,
    output logic                              err_drop
);
    localparam int DEST_W = $clog2(NODE_NUM);
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [DEST_W-1:0] JS   = DEST_W'(JUMP_STEP);
    localparam logic [CNT_W-1:0]  SMAX = CNT_W'(STARVE_MAX);
    localparam logic              JEN  = (JUMP_EN != 0);

    logic                         live;
    logic                         in_is_ej;
    logic                         fwd_vld;
    logic                         ld_ok;
    logic                         force_inj;
    logic                         fwd_go;
    logic                         inj_go;
    logic                         ej_push;
    logic                         ej_full;
    logic                         inj_push;
    logic                         inj_empty;
    logic [DATA_WIDTH-1:0]        inj_head_dat;
    logic [DEST_W-1:0]            inj_head_dest;
    logic                         inj_jump;
    logic [DEST_W-1:0]            fwd_dest;
    logic                         fwd_jump;
    logic [CNT_W-1:0]             starve_cnt;

    // Local writes with dest==0 never enter the FIFO; they only raise err_drop.
    assign inj_push = loc_wr && (loc_wr_dest != '0);

    ptr_ring_fifo #(.WIDTH(DATA_WIDTH + DEST_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inj_push),
        .push_dat ({loc_wr_dat, loc_wr_dest}),
        .pop      (inj_go),
        .pop_dat  ({inj_head_dat, inj_head_dest}),
        .full     (loc_full),
        .empty    (inj_empty)
    );

    ptr_ring_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ej_push),
        .push_dat (ring_in_dat),
        .pop      (loc_rd),
        .pop_dat  (loc_rd_dat),
        .full     (ej_full),
        .empty    (loc_empty)
    );

    // Holds ring_in_rdy low while reset is asserted and for the first cycle after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            live <= 1'b0;
        else
            live <= 1'b1;
    end

    // Classification, arbitration and handshakes; a forced injection blocks only forward traffic.
    always_comb begin
        in_is_ej    = (ring_in_dest == '0);
        fwd_vld     = live && ring_in_vld && !in_is_ej;
        ld_ok       = !ring_out_vld || ring_out_rdy;
        force_inj   = !inj_empty && (starve_cnt == SMAX);
        ring_in_rdy = live && (in_is_ej ? !ej_full : (ld_ok && !force_inj));
        ej_push     = ring_in_vld && in_is_ej && ring_in_rdy;
        fwd_go      = fwd_vld && ld_ok && !force_inj;
        inj_go      = ld_ok && !inj_empty && (force_inj || !fwd_vld);
        inj_jump    = JEN && (inj_head_dest >= JS);
    end

    // Hop arithmetic: an express hop needs enough distance left, otherwise the flit is demoted to a single step.
    always_comb begin
        fwd_dest = ring_in_dest - DEST_W'(1);
        fwd_jump = 1'b0;
        if (ring_in_jump && (ring_in_dest >= JS)) begin
            fwd_dest = ring_in_dest - JS;
            fwd_jump = JEN && ((ring_in_dest - JS) >= JS);
        end
    end

    // Single output stage; loads when empty or draining, otherwise holds every field.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring_out_vld  <= 1'b0;
            ring_out_dat  <= '0;
            ring_out_dest <= '0;
            ring_out_jump <= 1'b0;
        end else if (ld_ok) begin
            if (fwd_go) begin
                ring_out_vld  <= 1'b1;
                ring_out_dat  <= ring_in_dat;
                ring_out_dest <= fwd_dest;
                ring_out_jump <= fwd_jump;
            end else if (inj_go) begin
                ring_out_vld  <= 1'b1;
                ring_out_dat  <= inj_head_dat;
                ring_out_dest <= inj_head_dest;
                ring_out_jump <= inj_jump;
            end else begin
                ring_out_vld  <= 1'b0;
            end
        end
    end

    // Starvation counter: counts waiting cycles of a pending injection, saturating at the force threshold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (inj_empty || inj_go)
            starve_cnt <= '0;
        else if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Sticky flag for local writes addressed to this node.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_drop <= 1'b0;
        else if (loc_wr && (loc_wr_dest == '0))
            err_drop <= 1'b1;
    end
endmodule

// File: tb/tb_ptr_ring_router_v2.sv
// Self-checking bench for ptr_ring_router_v2 with a queue-based reference model.
// Inputs change 2 time units after the rising edge; outputs are read on the falling edge.
// Ring output transfers are collected by a monitor and compared against model queues.
module tb_ptr_ring_router_v2;
    localparam int DW  = 128;
    localparam int NN  = 128;
    localparam int DWD = 7;
    localparam int JS  = 4;
    localparam int SM  = 8;
    localparam int ID  = 4;
    localparam int ED  = 4;

    typedef logic [DW+DWD:0] rec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           ring_in_vld;
    logic           ring_in_rdy;
    logic [DW-1:0]  ring_in_dat;
    logic [DWD-1:0] ring_in_dest;
    logic           ring_in_jump;
    logic           ring_out_vld;
    logic           ring_out_rdy;
    logic [DW-1:0]  ring_out_dat;
    logic [DWD-1:0] ring_out_dest;
    logic           ring_out_jump;
    logic           loc_wr;
    logic [DW-1:0]  loc_wr_dat;
    logic [DWD-1:0] loc_wr_dest;
    logic           loc_full;
    logic           loc_rd;
    logic [DW-1:0]  loc_rd_dat;
    logic           loc_empty;
    logic           err_drop;

    int checks = 0;
    int errors = 0;
    rec_t out_q[$];

    ptr_ring_router_v2 #(
        .DATA_WIDTH(DW), .NODE_NUM(NN), .JUMP_STEP(JS), .JUMP_EN(1),
        .INJ_DEPTH(ID), .EJ_DEPTH(ED), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .ring_in_vld(ring_in_vld), .ring_in_rdy(ring_in_rdy), .ring_in_dat(ring_in_dat),
        .ring_in_dest(ring_in_dest), .ring_in_jump(ring_in_jump),
        .ring_out_vld(ring_out_vld), .ring_out_rdy(ring_out_rdy), .ring_out_dat(ring_out_dat),
        .ring_out_dest(ring_out_dest), .ring_out_jump(ring_out_jump),
        .loc_wr(loc_wr), .loc_wr_dat(loc_wr_dat), .loc_wr_dest(loc_wr_dest), .loc_full(loc_full),
        .loc_rd(loc_rd), .loc_rd_dat(loc_rd_dat), .loc_empty(loc_empty), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    // Ring output monitor: a flit seen valid with ready at the falling edge transfers on the next rising edge.
    always @(negedge clk) begin
        if (ring_out_vld && ring_out_rdy)
            out_q.push_back({ring_out_dat, ring_out_dest, ring_out_jump});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference hop rule for a forwarded flit.
    function automatic rec_t hop_ref(input logic [DW-1:0] d, input int dest, input bit j);
        int nd;
        bit nj;
        if (j && dest >= JS) begin
            nd = dest - JS;
            nj = (nd >= JS);
        end else begin
            nd = dest - 1;
            nj = 1'b0;
        end
        return {d, DWD'(nd), nj};
    endfunction

    // Reference for an injected flit: destination unchanged, express when far enough.
    function automatic rec_t inj_ref(input logic [DW-1:0] d, input int dest);
        return {d, DWD'(dest), (dest >= JS)};
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ring_in_vld = 1'b0;
        loc_wr      = 1'b0;
        loc_rd      = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            idle();
            ring_out_rdy = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        ring_in_dat = '0; ring_in_dest = '0; ring_in_jump = 1'b0;
        loc_wr_dat = '0; loc_wr_dest = '0; ring_out_rdy = 1'b0;
        #12;
        checks++;
        if ({ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump} !== '0) begin
            errors++;
            $display("FAIL reset_out: got vld=%b dat=%h dest=%0d jump=%b expected all zero", ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump);
        end
        checks++;
        if ({loc_full, loc_empty, err_drop, ring_in_rdy} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: got full/empty/err/rdy=%b expected 0100", {loc_full, loc_empty, err_drop, ring_in_rdy});
        end
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_forward();
        rec_t exp_q[$];
        logic [DW-1:0] d2, d3;
        bit pend;
        ring_out_rdy = 1'b1;
        d2 = rnd128();
        d3 = rnd128();
        cyc();
        ring_in_vld = 1'b1; ring_in_dat = 128'hA5; ring_in_dest = 7'd5; ring_in_jump = 1'b0;
        @(negedge clk);
        checks++;
        if (ring_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fwd_first_rdy: got %b expected 1", ring_in_rdy);
        end
        cyc();
        ring_in_dat = d2; ring_in_dest = 7'd9; ring_in_jump = 1'b1;
        @(negedge clk);
        checks++;
        if ({ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump} !== {1'b1, 128'hA5, 7'd4, 1'b0}) begin
            errors++;
            $display("FAIL fwd_plain: got vld=%b dat=%h dest=%0d jump=%b expected 1 a5 4 0", ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump);
        end
        cyc();
        ring_in_dat = d3; ring_in_dest = 7'd6; ring_in_jump = 1'b1;
        @(negedge clk);
        checks++;
        if ({ring_out_dat, ring_out_dest, ring_out_jump} !== {d2, 7'd5, 1'b1}) begin
            errors++;
            $display("FAIL fwd_express: got dest=%0d jump=%b expected 5 1", ring_out_dest, ring_out_jump);
        end
        cyc();
        ring_in_vld = 1'b0;
        @(negedge clk);
        checks++;
        if ({ring_out_dat, ring_out_dest, ring_out_jump} !== {d3, 7'd2, 1'b0}) begin
            errors++;
            $display("FAIL fwd_demote: got dest=%0d jump=%b expected 2 0", ring_out_dest, ring_out_jump);
        end
        drain(3);
        out_q.delete();
        pend = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (!pend) begin
                ring_in_vld  = ($urandom % 4) != 0;
                ring_in_dat  = rnd128();
                ring_in_dest = 7'($urandom_range(1, 127));
                ring_in_jump = 1'($urandom % 2);
            end
            ring_out_rdy = ($urandom % 4) != 0;
            @(negedge clk);
            if (ring_in_vld) begin
                checks++;
                if (ring_in_rdy !== (!ring_out_vld || ring_out_rdy)) begin
                    errors++;
                    $display("FAIL fwd_rand_rdy: got %b expected %b", ring_in_rdy, (!ring_out_vld || ring_out_rdy));
                end
            end
            pend = ring_in_vld && !ring_in_rdy;
            if (ring_in_vld && ring_in_rdy)
                exp_q.push_back(hop_ref(ring_in_dat, int'(ring_in_dest), ring_in_jump));
        end
        drain(4);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL fwd_rand_count: got %0d flits expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fwd_rand_flit[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_eject();
        logic [DW-1:0] ed[5];
        logic [DW-1:0] mq[$];
        bit pend, pushed;
        ring_out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) ed[i] = rnd128();
        for (int i = 0; i < 4; i++) begin
            cyc();
            ring_in_vld = 1'b1; ring_in_dest = '0; ring_in_jump = 1'b0; ring_in_dat = ed[i];
            @(negedge clk);
            checks++;
            if (ring_in_rdy !== 1'b1) begin
                errors++;
                $display("FAIL ej_fill_rdy[%0d]: got %b expected 1", i, ring_in_rdy);
            end
            if (i < 2) begin
                checks++;
                if (loc_empty !== (i == 0)) begin
                    errors++;
                    $display("FAIL ej_empty_timing[%0d]: got %b expected %b", i, loc_empty, (i == 0));
                end
            end
        end
        cyc();
        ring_in_dat = ed[4];
        @(negedge clk);
        checks++;
        if (ring_in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ej_full_rdy: got %b expected 0", ring_in_rdy);
        end
        cyc();
        loc_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (ring_in_rdy !== 1'b0 || loc_rd_dat !== ed[0]) begin
            errors++;
            $display("FAIL ej_pop_same_cycle: got rdy=%b head=%h expected rdy=0 head=%h", ring_in_rdy, loc_rd_dat, ed[0]);
        end
        cyc();
        loc_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (ring_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ej_after_pop_rdy: got %b expected 1", ring_in_rdy);
        end
        cyc();
        ring_in_vld = 1'b0;
        for (int j = 1; j < 5; j++) begin
            loc_rd = 1'b1;
            @(negedge clk);
            checks++;
            if (loc_rd_dat !== ed[j]) begin
                errors++;
                $display("FAIL ej_order[%0d]: got %h expected %h", j, loc_rd_dat, ed[j]);
            end
            cyc();
        end
        loc_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (loc_empty !== 1'b1) begin
            errors++;
            $display("FAIL ej_drained_empty: got %b expected 1", loc_empty);
        end
        pend = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (!pend) begin
                ring_in_vld = ($urandom % 3) != 0;
                ring_in_dat = rnd128();
            end
            ring_in_dest = '0;
            loc_rd = ($urandom % 3) == 0;
            @(negedge clk);
            checks++;
            if (loc_empty !== (mq.size() == 0)) begin
                errors++;
                $display("FAIL ej_rand_empty[%0d]: got %b expected %b", i, loc_empty, (mq.size() == 0));
            end
            if (mq.size() > 0) begin
                checks++;
                if (loc_rd_dat !== mq[0]) begin
                    errors++;
                    $display("FAIL ej_rand_head[%0d]: got %h expected %h", i, loc_rd_dat, mq[0]);
                end
            end
            if (ring_in_vld) begin
                checks++;
                if (ring_in_rdy !== (mq.size() < ED)) begin
                    errors++;
                    $display("FAIL ej_rand_rdy[%0d]: got %b expected %b", i, ring_in_rdy, (mq.size() < ED));
                end
            end
            pushed = ring_in_vld && (mq.size() < ED);
            if (loc_rd && mq.size() > 0)
                void'(mq.pop_front());
            if (pushed)
                mq.push_back(ring_in_dat);
            pend = ring_in_vld && !pushed;
        end
        for (int i = 0; i < ED + 1; i++) begin
            cyc();
            ring_in_vld = 1'b0;
            loc_rd = 1'b1;
            @(negedge clk);
            checks++;
            if (mq.size() > 0) begin
                if (loc_rd_dat !== mq[0]) begin
                    errors++;
                    $display("FAIL ej_tail_head[%0d]: got %h expected %h", i, loc_rd_dat, mq[0]);
                end
                void'(mq.pop_front());
            end else if (loc_empty !== 1'b1) begin
                errors++;
                $display("FAIL ej_tail_empty: got %b expected 1", loc_empty);
            end
        end
        cyc();
        idle();
    endtask

    task automatic test_inject();
        rec_t exp_q[$];
        logic [DW-1:0] a, b;
        a = rnd128();
        b = rnd128();
        out_q.delete();
        ring_out_rdy = 1'b1;
        cyc();
        loc_wr = 1'b1; loc_wr_dat = a; loc_wr_dest = 7'd10;
        cyc();
        loc_wr_dat = b; loc_wr_dest = 7'd3;
        cyc();
        loc_wr = 1'b0;
        @(negedge clk);
        drain(6);
        exp_q.push_back({a, 7'd10, 1'b1});
        exp_q.push_back({b, 7'd3, 1'b0});
        for (int i = 0; i < 40; i++) begin
            cyc();
            loc_wr = !loc_full && (($urandom % 2) != 0);
            loc_wr_dat = rnd128();
            loc_wr_dest = 7'($urandom_range(1, 127));
            ring_out_rdy = ($urandom % 3) != 0;
            if (loc_wr)
                exp_q.push_back(inj_ref(loc_wr_dat, int'(loc_wr_dest)));
            @(negedge clk);
        end
        drain(12);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL inj_count: got %0d flits expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL inj_flit[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_starvation();
        rec_t fexp[$];
        rec_t rest[$];
        rec_t inj_exp;
        logic [DW-1:0] inj_dat;
        bit acc;
        int k_seen;
        int n_inj;
        inj_dat = rnd128();
        inj_exp = inj_ref(inj_dat, 20);
        out_q.delete();
        ring_out_rdy = 1'b1;
        acc = 1'b1;
        k_seen = -1;
        for (int k = 0; k < SM + 8; k++) begin
            cyc();
            if (acc) begin
                ring_in_dat  = rnd128();
                ring_in_dest = 7'($urandom_range(1, 127));
                ring_in_jump = 1'($urandom % 2);
            end
            ring_in_vld = 1'b1;
            loc_wr = (k == 3);
            loc_wr_dat = inj_dat;
            loc_wr_dest = 7'd20;
            @(negedge clk);
            acc = ring_in_rdy;
            if (acc)
                fexp.push_back(hop_ref(ring_in_dat, int'(ring_in_dest), ring_in_jump));
            if (k > 3 && k_seen < 0 && ring_out_vld && ring_out_dat == inj_dat)
                k_seen = k - 3;
        end
        drain(4);
        checks++;
        if (k_seen < SM || k_seen > SM + 2) begin
            errors++;
            $display("FAIL starve_latency: got %0d cycles expected %0d..%0d", k_seen, SM, SM + 2);
        end
        n_inj = 0;
        foreach (out_q[i]) begin
            if (out_q[i] === inj_exp)
                n_inj++;
            else
                rest.push_back(out_q[i]);
        end
        checks++;
        if (n_inj != 1) begin
            errors++;
            $display("FAIL starve_inj_once: got %0d copies expected 1", n_inj);
        end
        checks++;
        if (rest.size() != fexp.size()) begin
            errors++;
            $display("FAIL starve_fwd_count: got %0d expected %0d", rest.size(), fexp.size());
        end
        for (int i = 0; i < fexp.size() && i < rest.size(); i++) begin
            checks++;
            if (rest[i] !== fexp[i]) begin
                errors++;
                $display("FAIL starve_fwd[%0d]: got %h expected %h", i, rest[i], fexp[i]);
            end
        end
    endtask

    task automatic test_out_stall();
        logic [DW-1:0] f1, f2;
        rec_t e1, e2;
        f1 = rnd128();
        f2 = rnd128();
        e1 = {f1, 7'd26, 1'b1};
        e2 = {f2, 7'd6, 1'b0};
        out_q.delete();
        cyc();
        ring_out_rdy = 1'b0;
        ring_in_vld = 1'b1; ring_in_dat = f1; ring_in_dest = 7'd30; ring_in_jump = 1'b1;
        @(negedge clk);
        checks++;
        if (ring_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_first_rdy: got %b expected 1", ring_in_rdy);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 0) begin
                ring_in_dat = f2; ring_in_dest = 7'd7; ring_in_jump = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump} !== {1'b1, e1} || ring_in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got vld=%b out=%h rdy=%b expected 1 %h 0", i, ring_out_vld, {ring_out_dat, ring_out_dest, ring_out_jump}, ring_in_rdy, e1);
            end
        end
        cyc();
        ring_out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (ring_in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_rdy: got %b expected 1", ring_in_rdy);
        end
        drain(3);
        checks++;
        if (out_q.size() != 2 || out_q[0] !== e1 || out_q[1] !== e2) begin
            errors++;
            $display("FAIL stall_order: got %0d flits first=%h expected 2 flits first=%h", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, e1);
        end
    endtask

    task automatic test_errors();
        logic [DW-1:0] a;
        logic [DW-1:0] w[5];
        int wd[5];
        rec_t exp_q[$];
        out_q.delete();
        ring_out_rdy = 1'b1;
        cyc();
        loc_wr = 1'b1; loc_wr_dat = rnd128(); loc_wr_dest = '0;
        @(negedge clk);
        checks++;
        if (err_drop !== 1'b0) begin
            errors++;
            $display("FAIL err_before_edge: got %b expected 0", err_drop);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            loc_wr = 1'b0;
            @(negedge clk);
            checks++;
            if (err_drop !== 1'b1 || ring_out_vld !== 1'b0) begin
                errors++;
                $display("FAIL err_sticky[%0d]: got err=%b out_vld=%b expected 1 0", i, err_drop, ring_out_vld);
            end
        end
        a = rnd128();
        cyc();
        ring_out_rdy = 1'b0;
        loc_wr = 1'b1; loc_wr_dat = a; loc_wr_dest = 7'd5;
        cyc();
        loc_wr = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if (ring_out_vld !== 1'b1 || ring_out_dat !== a) begin
            errors++;
            $display("FAIL ovf_preload: got vld=%b dat=%h expected 1 %h", ring_out_vld, ring_out_dat, a);
        end
        for (int i = 0; i < 5; i++) begin
            w[i] = rnd128();
            wd[i] = $urandom_range(1, 127);
            cyc();
            loc_wr = 1'b1; loc_wr_dat = w[i]; loc_wr_dest = 7'(wd[i]);
            @(negedge clk);
        end
        checks++;
        if (loc_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got %b expected 1", loc_full);
        end
        exp_q.push_back(inj_ref(a, 5));
        for (int i = 0; i < 4; i++) exp_q.push_back(inj_ref(w[i], wd[i]));
        drain(10);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_count: got %0d flits expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_flit[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midtraffic();
        cyc();
        ring_out_rdy = 1'b0;
        ring_in_vld = 1'b1; ring_in_dat = rnd128(); ring_in_dest = 7'd5; ring_in_jump = 1'b0;
        cyc();
        ring_in_dat = rnd128(); ring_in_dest = '0;
        loc_wr = 1'b1; loc_wr_dat = rnd128(); loc_wr_dest = 7'd9;
        cyc();
        ring_in_dat = rnd128();
        loc_wr_dat = rnd128();
        cyc();
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump} !== '0) begin
            errors++;
            $display("FAIL midrst_out: got vld=%b dat=%h dest=%0d jump=%b expected all zero", ring_out_vld, ring_out_dat, ring_out_dest, ring_out_jump);
        end
        checks++;
        if ({loc_full, loc_empty, err_drop, ring_in_rdy} !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_flags: got full/empty/err/rdy=%b expected 0100", {loc_full, loc_empty, err_drop, ring_in_rdy});
        end
        idle();
        cyc();
        cyc();
        rst = 1'b1;
        ring_out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            @(negedge clk);
            checks++;
            if (ring_out_vld !== 1'b0 || loc_empty !== 1'b1) begin
                errors++;
                $display("FAIL midrst_stale[%0d]: got out_vld=%b loc_empty=%b expected 0 1", i, ring_out_vld, loc_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_eject();
        test_inject();
        test_starvation();
        test_out_stall();
        test_errors();
        test_reset_midtraffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
